// File: rtl/demux_registrado_n.sv
// Registered 1xN demultiplexer: routes each write into one of CANAIS channel registers,
// addressed by sel or by an auto-incrementing pointer, with valid/complete/error flags.
module demux_registrado_n #(
    parameter int unsigned BITS     = 3,
    parameter int unsigned CANAIS   = 8,
    parameter int unsigned SEL_BITS = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     limpa,
    input  logic                     escreve,
    input  logic                     modo,
    input  logic [SEL_BITS-1:0]      sel,
    input  logic [BITS-1:0]          entrada,
    output logic [CANAIS*BITS-1:0]   saidas,
    output logic [CANAIS-1:0]        validos,
    output logic [SEL_BITS-1:0]      ponteiro,
    output logic                     completo,
    output logic                     erro
);

    localparam logic [SEL_BITS:0]   NUM_CANAIS = (SEL_BITS + 1)'(CANAIS);
    localparam logic [SEL_BITS-1:0] ULTIMO     = SEL_BITS'(CANAIS - 1);

    logic [SEL_BITS-1:0] alvo;
    logic                alvo_ok;
    logic [CANAIS-1:0]   alvo_oh;
    logic [SEL_BITS-1:0] prox_ponteiro;

    always_comb begin
        alvo    = modo ? ponteiro : sel;
        alvo_ok = {1'b0, alvo} < NUM_CANAIS;
        alvo_oh = '0;
        for (int k = 0; k < int'(CANAIS); k++) begin
            alvo_oh[k] = (alvo == SEL_BITS'(k));
        end
        // Wrap at CANAIS rather than at 2**SEL_BITS
        prox_ponteiro = (alvo == ULTIMO) ? '0 : alvo + 1'b1;
    end

    assign completo = &validos;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            saidas   <= '0;
            validos  <= '0;
            ponteiro <= '0;
            erro     <= 1'b0;
        end else if (limpa) begin
            saidas   <= '0;
            validos  <= '0;
            ponteiro <= '0;
            erro     <= 1'b0;
        end else begin
            erro <= escreve && !alvo_ok;
            if (escreve && alvo_ok) begin
                for (int k = 0; k < int'(CANAIS); k++) begin
                    if (alvo_oh[k]) begin
                        saidas[k*BITS +: BITS] <= entrada;
                    end
                end
                validos <= validos | alvo_oh;
                if (modo) begin
                    ponteiro <= prox_ponteiro;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux_registrado_n.sv
// Directed bench for demux_registrado_n: an 8-channel instance and a 6-channel instance
// sharing stimulus, used for range-error and wrap-at-CANAIS cases.
module tb_demux_registrado_n;

    logic        clock;
    logic        reset;
    logic        limpa;
    logic        escreve;
    logic        modo;
    logic [2:0]  sel;
    logic [2:0]  entrada;

    logic [23:0] saidas;
    logic [7:0]  validos;
    logic [2:0]  ponteiro;
    logic        completo;
    logic        erro;

    logic [17:0] saidas6;
    logic [5:0]  validos6;
    logic [2:0]  ponteiro6;
    logic        completo6;
    logic        erro6;

    int checks = 0;
    int errors = 0;

    demux_registrado_n #(.BITS(3), .CANAIS(8), .SEL_BITS(3)) u_dut (
        .clock    (clock),
        .reset    (reset),
        .limpa    (limpa),
        .escreve  (escreve),
        .modo     (modo),
        .sel      (sel),
        .entrada  (entrada),
        .saidas   (saidas),
        .validos  (validos),
        .ponteiro (ponteiro),
        .completo (completo),
        .erro     (erro)
    );

    demux_registrado_n #(.BITS(3), .CANAIS(6), .SEL_BITS(3)) u_dut6 (
        .clock    (clock),
        .reset    (reset),
        .limpa    (limpa),
        .escreve  (escreve),
        .modo     (modo),
        .sel      (sel),
        .entrada  (entrada),
        .saidas   (saidas6),
        .validos  (validos6),
        .ponteiro (ponteiro6),
        .completo (completo6),
        .erro     (erro6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (saidas !== 24'h0) begin
            errors++;
            $display("FAIL reset_saidas got %h exp %h", saidas, 24'h0);
        end
        checks++;
        if (validos !== 8'h00) begin
            errors++;
            $display("FAIL reset_validos got %h exp %h", validos, 8'h00);
        end
        checks++;
        if (ponteiro !== 3'd0) begin
            errors++;
            $display("FAIL reset_ponteiro got %0d exp %0d", ponteiro, 0);
        end
        checks++;
        if (completo !== 1'b0 || erro !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got completo=%b erro=%b exp 0 0", completo, erro);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_addressed();
        modo = 1'b0; sel = 3'd5; entrada = 3'b001; escreve = 1'b1;
        step();
        escreve = 1'b0;
        checks++;
        if (saidas !== 24'h008000) begin
            errors++;
            $display("FAIL addr_saidas got %h exp %h", saidas, 24'h008000);
        end
        checks++;
        if (validos !== 8'b0010_0000 || ponteiro !== 3'd0 || erro !== 1'b0) begin
            errors++;
            $display("FAIL addr_state got v=%h p=%0d e=%b exp v=20 p=0 e=0",
                     validos, ponteiro, erro);
        end
        step();
        checks++;
        if (saidas !== 24'h008000 || validos !== 8'h20) begin
            errors++;
            $display("FAIL addr_hold got s=%h v=%h exp s=008000 v=20", saidas, validos);
        end
    endtask

    task automatic test_sequential_fill();
        logic [23:0] exp_s;
        exp_s = 24'h0;
        modo = 1'b1;
        for (int k = 0; k < 8; k++) begin
            entrada = 3'(k);
            escreve = 1'b1;
            step();
            checks++;
            if (ponteiro !== 3'((k + 1) % 8)) begin
                errors++;
                $display("FAIL seq_ponteiro_%0d got %0d exp %0d", k, ponteiro, (k + 1) % 8);
            end
        end
        escreve = 1'b0;
        for (int k = 0; k < 8; k++) exp_s[k*3 +: 3] = 3'(k);
        checks++;
        if (saidas !== exp_s) begin
            errors++;
            $display("FAIL seq_saidas got %h exp %h", saidas, exp_s);
        end
        checks++;
        if (validos !== 8'hFF || completo !== 1'b1) begin
            errors++;
            $display("FAIL seq_full got v=%h c=%b exp v=ff c=1", validos, completo);
        end
        entrada = 3'b111; escreve = 1'b1;
        step();
        escreve = 1'b0;
        exp_s[2:0] = 3'b111;
        checks++;
        if (saidas !== exp_s || ponteiro !== 3'd1 || completo !== 1'b1) begin
            errors++;
            $display("FAIL seq_ninth got s=%h p=%0d c=%b exp s=%h p=1 c=1",
                     saidas, ponteiro, completo, exp_s);
        end
    endtask

    task automatic test_modo_switch();
        modo = 1'b0; sel = 3'd3; entrada = 3'd5; escreve = 1'b1;
        step();
        modo = 1'b1; entrada = 3'd2;
        step();
        escreve = 1'b0;
        checks++;
        if (saidas[11:9] !== 3'd5 || saidas[5:3] !== 3'd2 || ponteiro !== 3'd2) begin
            errors++;
            $display("FAIL modo_switch got ch3=%0d ch1=%0d p=%0d exp ch3=5 ch1=2 p=2",
                     saidas[11:9], saidas[5:3], ponteiro);
        end
    endtask

    task automatic test_precedence();
        limpa = 1'b1; escreve = 1'b1; modo = 1'b1; entrada = 3'd6;
        step();
        limpa = 1'b0; escreve = 1'b0;
        checks++;
        if (saidas !== 24'h0 || validos !== 8'h00 || ponteiro !== 3'd0) begin
            errors++;
            $display("FAIL prec_state got s=%h v=%h p=%0d exp 0 0 0", saidas, validos, ponteiro);
        end
        checks++;
        if (completo !== 1'b0 || erro !== 1'b0) begin
            errors++;
            $display("FAIL prec_flags got c=%b e=%b exp 0 0", completo, erro);
        end
    endtask

    task automatic test_range_error();
        modo = 1'b0; sel = 3'd7; entrada = 3'd3; escreve = 1'b1;
        step();
        checks++;
        if (erro6 !== 1'b1 || saidas6 !== 18'h0 || validos6 !== 6'h00) begin
            errors++;
            $display("FAIL range_err got e=%b s=%h v=%h exp e=1 s=0 v=0", erro6, saidas6, validos6);
        end
        sel = 3'd5; entrada = 3'd4;
        step();
        escreve = 1'b0;
        checks++;
        if (erro6 !== 1'b0 || saidas6 !== 18'h20000 || validos6 !== 6'b100000) begin
            errors++;
            $display("FAIL range_ok got e=%b s=%h v=%h exp e=0 s=20000 v=20",
                     erro6, saidas6, validos6);
        end
        sel = 3'd6; escreve = 1'b1;
        step();
        escreve = 1'b0;
        step();
        checks++;
        if (erro6 !== 1'b0 || validos6 !== 6'b100000) begin
            errors++;
            $display("FAIL range_pulse got e=%b v=%h exp e=0 v=20", erro6, validos6);
        end
        // Sequential wrap must happen at 6 on the small instance
        limpa = 1'b1;
        step();
        limpa = 1'b0; modo = 1'b1; escreve = 1'b1;
        for (int k = 0; k < 6; k++) begin
            entrada = 3'(k + 1);
            step();
        end
        escreve = 1'b0;
        checks++;
        if (ponteiro6 !== 3'd0 || completo6 !== 1'b1 || erro6 !== 1'b0) begin
            errors++;
            $display("FAIL wrap6 got p=%0d c=%b e=%b exp p=0 c=1 e=0", ponteiro6, completo6, erro6);
        end
    endtask

    task automatic test_async_reset();
        limpa = 1'b1;
        step();
        limpa = 1'b0; modo = 1'b1; escreve = 1'b1;
        for (int k = 0; k < 3; k++) begin
            entrada = 3'(k + 2);
            step();
        end
        escreve = 1'b0;
        checks++;
        if (ponteiro !== 3'd3) begin
            errors++;
            $display("FAIL async_pre got p=%0d exp 3", ponteiro);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (saidas !== 24'h0 || validos !== 8'h00 || ponteiro !== 3'd0 ||
            completo !== 1'b0 || erro !== 1'b0) begin
            errors++;
            $display("FAIL async_clear got s=%h v=%h p=%0d c=%b e=%b exp all 0",
                     saidas, validos, ponteiro, completo, erro);
        end
        @(negedge clock);
        reset = 1'b0;
        entrada = 3'd5; escreve = 1'b1;
        step();
        escreve = 1'b0;
        checks++;
        if (saidas !== 24'h000005 || validos !== 8'h01 || ponteiro !== 3'd1) begin
            errors++;
            $display("FAIL async_restart got s=%h v=%h p=%0d exp s=000005 v=01 p=1",
                     saidas, validos, ponteiro);
        end
    endtask

    initial begin
        reset = 1'b0; limpa = 1'b0; escreve = 1'b0; modo = 1'b0;
        sel = 3'd0; entrada = 3'd0;
        test_reset();
        test_addressed();
        test_sequential_fill();
        test_modo_switch();
        test_precedence();
        test_range_error();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
